bsg_channel_widen: RTL and testbench

//  Deserializer that packs mult_p consecutive narrow beats into one wide word; the

---
 rtl/bsg_channel_widen_pkg.sv | 18 +
 rtl/bsg_widen_beat_counter.sv | 26 ++
 rtl/bsg_channel_widen.sv | 113 +++++++++++
 tb/tb_bsg_channel_widen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_channel_widen_pkg.sv
// Width helpers shared by the channel widener and its beat counter.
// Pure constants and types; no logic, no latency, no flow control.
package bsg_channel_widen_pkg;

    localparam int default_width_in_lp = 8;

    typedef logic [default_width_in_lp-1:0] beat_slice_t;

    function automatic int width_out_lp(input int width_in, input int mult);
        return width_in * mult;
    endfunction

    // A one-bit counter is still needed when mult collapses to 1 or 2.
    function automatic int count_width_lp(input int mult);
        return (mult <= 2) ? 1 : $clog2(mult);
    endfunction

endpackage

// File: rtl/bsg_widen_beat_counter.sv
// Beat index counter that wraps to zero after max_val_p; wrap_o flags the wrapping step.
// Latency: count_o updates on the edge where en_i is high; no backpressure of its own.
module bsg_widen_beat_counter #(
    parameter int max_val_p = 1,
    parameter int width_p   = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o,
    output logic               wrap_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_val_p);

    assign wrap_o = en_i & (count_o == max_lp);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_o <= '0;
        end else if (en_i) begin
            count_o <= wrap_o ? '0 : count_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bsg_channel_widen.sv
// Packs mult_p narrow beats into one wide word; word appears the cycle after its last beat.
// Backpressure: only the last beat stalls (ready_o=0) while a previous word awaits yumi_i.
module bsg_channel_widen
    import bsg_channel_widen_pkg::*;
#(
    parameter int width_in_p  = 8,
    parameter int mult_p      = 2,
    parameter int lsb_first_p = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [width_in_p-1:0]                  data_i,
    input  logic                                   v_i,
    output logic                                   ready_o,
    output logic [width_out_lp(width_in_p, mult_p)-1:0] data_o,
    output logic                                   v_o,
    input  logic                                   yumi_i
);

    localparam int wout_lp = width_out_lp(width_in_p, mult_p);
    localparam int cw_lp   = count_width_lp(mult_p);
    localparam logic [cw_lp-1:0] last_cnt_lp = cw_lp'(mult_p - 1);

    if (mult_p < 2) begin : g_bad_mult
        $error("bsg_channel_widen: mult_p must be >= 2");
    end

    logic [cw_lp-1:0]                   count_r;
    logic                               complete;
    logic                               accept;
    logic [width_in_p*(mult_p-1)-1:0]   accum_r;
    logic [wout_lp-1:0]                 word_n;
    logic [wout_lp-1:0]                 out_r;
    logic                               v_r;

    // The last beat needs a free holding register; yumi_i frees it in the same cycle.
    assign ready_o = (count_r != last_cnt_lp) | ~v_r | yumi_i;
    assign accept  = v_i & ready_o;
    assign data_o  = out_r;
    assign v_o     = v_r;

    bsg_widen_beat_counter #(
        .max_val_p (mult_p - 1),
        .width_p   (cw_lp)
    ) u_counter (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (accept),
        .count_o   (count_r),
        .wrap_o    (complete)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            accum_r <= '0;
        end else if (accept && !complete) begin
            for (int k = 0; k < mult_p - 1; k++) begin
                if (count_r == cw_lp'(k)) begin
                    accum_r[k*width_in_p +: width_in_p] <= data_i;
                end
            end
        end
    end

    always_comb begin
        word_n = '0;
        for (int k = 0; k < mult_p - 1; k++) begin
            word_n[((lsb_first_p != 0) ? k : (mult_p - 1 - k))*width_in_p +: width_in_p]
                = accum_r[k*width_in_p +: width_in_p];
        end
        word_n[((lsb_first_p != 0) ? (mult_p - 1) : 0)*width_in_p +: width_in_p] = data_i;
    end

    // Completion wins over yumi_i so a same-cycle handoff keeps v_r asserted.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_r <= '0;
            v_r   <= 1'b0;
        end else if (complete) begin
            out_r <= word_n;
            v_r   <= 1'b1;
        end else if (yumi_i) begin
            v_r   <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    logic               hold_q;
    logic [wout_lp-1:0] data_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_q <= 1'b0;
            data_q <= '0;
        end else begin
            hold_q <= v_r & ~yumi_i;
            data_q <= out_r;
        end
    end

    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !v_r))
                else $error("bsg_channel_widen: yumi_i asserted while v_o is low");
            if (hold_q) begin
                assert (out_r == data_q)
                    else $error("bsg_channel_widen: data_o changed while held");
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_channel_widen.sv
// Directed and randomised checks of bsg_channel_widen across four parameterisations.
module tb_bsg_channel_widen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // a: mult 2 lsb-first, b: mult 2 msb-first, c: mult 3, d: mult 4
    logic [7:0]  data_a = '0, data_b = '0, data_c = '0, data_d = '0;
    logic        v_a = 0, v_b = 0, v_c = 0, v_d = 0;
    logic        yumi_a = 0, yumi_b = 0, yumi_c = 0, yumi_d = 0;
    logic        rdy_a, rdy_b, rdy_c, rdy_d;
    logic        vo_a, vo_b, vo_c, vo_d;
    logic [15:0] dout_a, dout_b;
    logic [23:0] dout_c;
    logic [31:0] dout_d;

    bsg_channel_widen #(.width_in_p(8), .mult_p(2), .lsb_first_p(1)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data_a), .v_i(v_a), .ready_o(rdy_a),
        .data_o(dout_a), .v_o(vo_a), .yumi_i(yumi_a));
    bsg_channel_widen #(.width_in_p(8), .mult_p(2), .lsb_first_p(0)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data_b), .v_i(v_b), .ready_o(rdy_b),
        .data_o(dout_b), .v_o(vo_b), .yumi_i(yumi_b));
    bsg_channel_widen #(.width_in_p(8), .mult_p(3), .lsb_first_p(1)) dut_c (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data_c), .v_i(v_c), .ready_o(rdy_c),
        .data_o(dout_c), .v_o(vo_c), .yumi_i(yumi_c));
    bsg_channel_widen #(.width_in_p(8), .mult_p(4), .lsb_first_p(1)) dut_d (
        .clk_i(clk), .reset_n_i(rst_n), .data_i(data_d), .v_i(v_d), .ready_o(rdy_d),
        .data_o(dout_d), .v_o(vo_d), .yumi_i(yumi_d));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_vec++; if (vo_a !== 1'b0) begin n_err++; $display("FAIL reset_v_o got %b want 0", vo_a); end
        n_vec++; if (dout_a !== 16'h0) begin n_err++; $display("FAIL reset_data_o got %h want 0000", dout_a); end
        tick();
        rst_n = 1'b1;
        #1;
        n_vec++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL reset_ready_o got %b want 1", rdy_a); end
        n_vec++; if (dout_d !== 32'h0) begin n_err++; $display("FAIL reset_data_o_m4 got %h want 0", dout_d); end
    endtask

    task automatic test_basic();
        tick(); data_a = 8'h34; v_a = 1; #1;
        n_vec++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL basic_ready got %b want 1", rdy_a); end
        tick(); data_a = 8'h12; #1;
        n_vec++; if (vo_a !== 1'b0) begin n_err++; $display("FAIL basic_early_v got %b want 0", vo_a); end
        tick(); v_a = 0; #1;
        n_vec++; if (vo_a !== 1'b1) begin n_err++; $display("FAIL basic_v got %b want 1", vo_a); end
        n_vec++; if (dout_a !== 16'h1234) begin n_err++; $display("FAIL basic_data got %h want 1234", dout_a); end
        yumi_a = 1;
        tick(); yumi_a = 0; #1;
        n_vec++; if (vo_a !== 1'b0) begin n_err++; $display("FAIL basic_drain got %b want 0", vo_a); end
    endtask

    task automatic test_msb_first();
        tick(); data_b = 8'h34; v_b = 1;
        tick(); data_b = 8'h12;
        tick(); v_b = 0; #1;
        n_vec++; if (vo_b !== 1'b1) begin n_err++; $display("FAIL msb_v got %b want 1", vo_b); end
        n_vec++; if (dout_b !== 16'h3412) begin n_err++; $display("FAIL msb_data got %h want 3412", dout_b); end
        yumi_b = 1;
        tick(); yumi_b = 0;
    endtask

    task automatic test_backpressure();
        tick(); data_a = 8'hAA; v_a = 1;
        tick(); data_a = 8'hBB;
        tick(); data_a = 8'hCC; #1;
        n_vec++; if (vo_a !== 1'b1) begin n_err++; $display("FAIL bp_v got %b want 1", vo_a); end
        n_vec++; if (dout_a !== 16'hBBAA) begin n_err++; $display("FAIL bp_word0 got %h want bbaa", dout_a); end
        n_vec++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL bp_first_beat_ready got %b want 1", rdy_a); end
        tick(); data_a = 8'hDD; #1;
        n_vec++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL bp_stall got %b want 0", rdy_a); end
        tick(); #1;
        n_vec++; if (rdy_a !== 1'b0) begin n_err++; $display("FAIL bp_stall2 got %b want 0", rdy_a); end
        n_vec++; if (dout_a !== 16'hBBAA) begin n_err++; $display("FAIL bp_hold got %h want bbaa", dout_a); end
        yumi_a = 1; #1;
        n_vec++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL bp_yumi_ready got %b want 1", rdy_a); end
        tick(); v_a = 0; yumi_a = 0; #1;
        n_vec++; if (vo_a !== 1'b1) begin n_err++; $display("FAIL bp_v2 got %b want 1", vo_a); end
        n_vec++; if (dout_a !== 16'hDDCC) begin n_err++; $display("FAIL bp_word1 got %h want ddcc", dout_a); end
        yumi_a = 1;
        tick(); yumi_a = 0; #1;
        n_vec++; if (vo_a !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", vo_a); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_w [4];
        int nw;
        exp_w = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
        nw = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            v_a = (cyc < 8);
            data_a = 8'(cyc);
            yumi_a = vo_a;
            #1;
            if (cyc < 8) begin
                n_vec++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL b2b_ready cycle %0d got %b want 1", cyc, rdy_a); end
            end
            if (vo_a) begin
                n_vec++; if (cyc !== 2 + 2*nw) begin n_err++; $display("FAIL b2b_cadence got cycle %0d want %0d", cyc, 2 + 2*nw); end
                if (nw < 4) begin
                    n_vec++; if (dout_a !== exp_w[nw]) begin n_err++; $display("FAIL b2b_word%0d got %h want %h", nw, dout_a, exp_w[nw]); end
                end
                nw++;
            end
        end
        tick(); v_a = 0; yumi_a = 0;
        n_vec++; if (nw !== 4) begin n_err++; $display("FAIL b2b_count got %0d want 4", nw); end
    endtask

    task automatic test_reset_mid_word();
        tick(); data_c = 8'h11; v_c = 1;
        tick(); data_c = 8'h22;
        tick(); v_c = 0; #1;
        n_vec++; if (vo_c !== 1'b0) begin n_err++; $display("FAIL mid_partial_v got %b want 0", vo_c); end
        rst_n = 1'b0; #1;
        n_vec++; if (vo_c !== 1'b0) begin n_err++; $display("FAIL mid_reset_v got %b want 0", vo_c); end
        n_vec++; if (dout_c !== 24'h0) begin n_err++; $display("FAIL mid_reset_data got %h want 000000", dout_c); end
        tick(); rst_n = 1'b1;
        tick(); data_c = 8'hA1; v_c = 1;
        tick(); data_c = 8'hA2; #1;
        n_vec++; if (vo_c !== 1'b0) begin n_err++; $display("FAIL mid_stale_v got %b want 0", vo_c); end
        tick(); data_c = 8'hA3;
        tick(); v_c = 0; #1;
        n_vec++; if (vo_c !== 1'b1) begin n_err++; $display("FAIL mid_v got %b want 1", vo_c); end
        n_vec++; if (dout_c !== 24'hA3A2A1) begin n_err++; $display("FAIL mid_data got %h want a3a2a1", dout_c); end
        yumi_c = 1;
        tick(); yumi_c = 0;
    endtask

    task automatic test_random();
        logic [7:0]  q [$];
        logic [31:0] expw;
        int sent, words, cyc;
        sent = 0; words = 0; cyc = 0;
        while ((sent < 10000 || words < 2500) && cyc < 60000) begin
            tick();
            cyc++;
            v_d = (sent < 10000) && ($urandom_range(3) != 0);
            data_d = 8'($urandom);
            yumi_d = vo_d && ($urandom_range(1) == 1);
            #1;
            if (v_d && rdy_d) begin
                q.push_back(data_d);
                sent++;
            end
            if (yumi_d) begin
                if (q.size() < 4) begin
                    n_vec++; n_err++;
                    $display("FAIL rand_underflow word %0d got %0d queued beats want 4", words, q.size());
                end else begin
                    expw = {q[3], q[2], q[1], q[0]};
                    repeat (4) void'(q.pop_front());
                    n_vec++; if (dout_d !== expw) begin n_err++; $display("FAIL rand_word%0d got %h want %h", words, dout_d, expw); end
                end
                words++;
            end
        end
        tick(); v_d = 0; yumi_d = 0;
        n_vec++; if (words !== 2500 || sent !== 10000) begin n_err++; $display("FAIL rand_totals got %0d words %0d beats want 2500 10000", words, sent); end
        n_vec++; if (q.size() !== 0) begin n_err++; $display("FAIL rand_leftover got %0d beats want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_msb_first();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
